// File: rtl/block_split_fifo_if.sv
// rtl/block_split_fifo_if.sv - producer/consumer signal bundle for block_split_fifo
interface block_split_fifo_if #(
    parameter int BLOCK_W = 64,
    parameter int DEPTH   = 4
);
    localparam int H  = BLOCK_W / 2;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [BLOCK_W-1:0] in_data;
    logic               in_swap;
    logic               in_valid;
    logic               in_ready;
    logic [H-1:0]       L_out;
    logic [H-1:0]       R_out;
    logic               out_valid;
    logic               out_ready;
    logic [CW-1:0]      count;

    modport slave (
        input  in_data, in_swap, in_valid, out_ready,
        output in_ready, L_out, R_out, out_valid, count
    );

    modport master (
        output in_data, in_swap, in_valid, out_ready,
        input  in_ready, L_out, R_out, out_valid, count
    );
endinterface

// File: rtl/block_split_fifo.sv
// rtl/block_split_fifo.sv - FIFO that splits each block into L/R halves, optional swap at write
module block_split_fifo #(
    parameter int BLOCK_W = 64,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    block_split_fifo_if.slave  bus
);
    localparam int H  = BLOCK_W / 2;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [H-1:0]  mem_l_q [DEPTH];
    logic [H-1:0]  mem_r_q [DEPTH];
    logic          push, pop;
    logic [H-1:0]  wr_l, wr_r;

    // Handshake flags come only from the registered count, so out_ready never reaches in_ready.
    assign bus.in_ready  = (count_q != CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign wr_l = bus.in_swap ? bus.in_data[H-1:0]       : bus.in_data[BLOCK_W-1:H];
    assign wr_r = bus.in_swap ? bus.in_data[BLOCK_W-1:H] : bus.in_data[H-1:0];

    // Storage is never cleared, so the visible halves are masked to zero while empty.
    assign bus.L_out = bus.out_valid ? mem_l_q[rd_ptr_q] : '0;
    assign bus.R_out = bus.out_valid ? mem_r_q[rd_ptr_q] : '0;
    assign bus.count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_l_q[wr_ptr_q] <= wr_l;
            mem_r_q[wr_ptr_q] <= wr_r;
        end
    end
endmodule

// File: tb/tb_block_split_fifo.sv
// tb/tb_block_split_fifo.sv - scoreboard bench for block_split_fifo (64/4 and 8/2 instances)
module tb_block_split_fifo;
    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    entry_t sb[$];

    always #5 clk = ~clk;

    block_split_fifo_if #(.BLOCK_W(64), .DEPTH(4)) a ();
    block_split_fifo_if #(.BLOCK_W(8),  .DEPTH(2)) b ();

    block_split_fifo #(.BLOCK_W(64), .DEPTH(4)) u_wide (.clk(clk), .rst(rst), .bus(a.slave));
    block_split_fifo #(.BLOCK_W(8),  .DEPTH(2)) u_narrow (.clk(clk), .rst(rst), .bus(b.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] l, input logic [31:0] r);
        entry_t e;
        e.l = l;
        e.r = r;
        sb.push_back(e);
    endtask

    // Monitor: every handshake the wide instance presents is matched against the scoreboard.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (!rst && a.out_valid === 1'b1 && a.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got L=%0h R=%0h expected no output", a.L_out, a.R_out);
                end else begin
                    e = sb.pop_front();
                    chk("sb_L", 64'(a.L_out), 64'(e.l));
                    chk("sb_R", 64'(a.R_out), 64'(e.r));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        a.in_data = '0; a.in_swap = 1'b0; a.in_valid = 1'b0; a.out_ready = 1'b0;
        b.in_data = '0; b.in_swap = 1'b0; b.in_valid = 1'b0; b.out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_count",    64'(a.count),     64'd0);
        chk("rst_out_valid", 64'(a.out_valid), 64'd0);
        chk("rst_in_ready", 64'(a.in_ready),  64'd1);
        chk("rst_L",        64'(a.L_out),     64'd0);
        chk("rst_R",        64'(a.R_out),     64'd0);

        // Basic split, then swap
        for (int k = 0; k < 2; k++) begin
            a.out_ready = 1'b1;
            a.in_valid  = 1'b1;
            a.in_data   = 64'h0123456789ABCDEF;
            a.in_swap   = k[0];
            if (k == 0) expect_entry(32'h01234567, 32'h89ABCDEF);
            else        expect_entry(32'h89ABCDEF, 32'h01234567);
            chk("no_bypass", 64'(a.out_valid), 64'd0);
            cyc();
            a.in_valid = 1'b0;
            chk("latency_valid", 64'(a.out_valid), 64'd1);
            chk("latency_count", 64'(a.count), 64'd1);
            cyc();
            chk("drained_valid", 64'(a.out_valid), 64'd0);
        end

        // Fill and backpressure
        a.out_ready = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            chk("fill_in_ready", 64'(a.in_ready), 64'd1);
            a.in_valid = 1'b1;
            a.in_data  = 64'(n);
            a.in_swap  = 1'b0;
            expect_entry(32'd0, 32'(n));
            cyc();
        end
        chk("full_in_ready", 64'(a.in_ready), 64'd0);
        chk("full_count",    64'(a.count),    64'd4);
        a.in_data = 64'd5;
        cyc();
        a.in_valid = 1'b0;
        chk("full_no_push", 64'(a.count), 64'd4);
        a.out_ready = 1'b1;
        cyc();
        chk("after_pop_in_ready", 64'(a.in_ready), 64'd1);
        chk("after_pop_count",    64'(a.count),    64'd3);
        cyc();
        cyc();
        cyc();
        chk("drain_count", 64'(a.count), 64'd0);
        chk("drain_valid", 64'(a.out_valid), 64'd0);

        // Simultaneous push/pop at count=2 across the pointer wrap
        a.out_ready = 1'b0;
        a.in_valid  = 1'b1;
        a.in_data = 64'hAAAA_AAAA_1111_1111; expect_entry(32'hAAAAAAAA, 32'h11111111); cyc();
        a.in_data = 64'hBBBB_BBBB_2222_2222; expect_entry(32'hBBBBBBBB, 32'h22222222); cyc();
        chk("pp_count_start", 64'(a.count), 64'd2);
        a.out_ready = 1'b1;
        a.in_data = 64'hCCCC_CCCC_3333_3333; expect_entry(32'hCCCCCCCC, 32'h33333333); cyc();
        chk("pp_count_c", 64'(a.count), 64'd2);
        a.in_swap = 1'b1;
        a.in_data = 64'hDDDD_DDDD_4444_4444; expect_entry(32'h44444444, 32'hDDDDDDDD); cyc();
        chk("pp_count_d", 64'(a.count), 64'd2);
        a.in_swap = 1'b0;
        a.in_data = 64'hEEEE_EEEE_5555_5555; expect_entry(32'hEEEEEEEE, 32'h55555555); cyc();
        chk("pp_count_e", 64'(a.count), 64'd2);
        a.in_data = 64'hFFFF_FFFF_6666_6666; expect_entry(32'hFFFFFFFF, 32'h66666666); cyc();
        chk("pp_count_f", 64'(a.count), 64'd2);
        a.in_valid = 1'b0;
        cyc();
        cyc();
        chk("pp_drain_count", 64'(a.count), 64'd0);
        chk("pp_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-operation with an in-flight block
        a.out_ready = 1'b0;
        a.in_valid  = 1'b1;
        a.in_data = 64'h0000_0011_0000_0022; expect_entry(32'h00000011, 32'h00000022); cyc();
        a.in_data = 64'h0000_0033_0000_0044; expect_entry(32'h00000033, 32'h00000044); cyc();
        a.in_data = 64'h0000_0055_0000_0066; expect_entry(32'h00000055, 32'h00000066); cyc();
        a.in_valid = 1'b0;
        chk("pre_rst_count", 64'(a.count), 64'd3);
        rst = 1'b1;
        a.in_valid = 1'b1;
        a.in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        sb.delete();
        cyc();
        rst = 1'b0;
        a.in_valid = 1'b0;
        chk("mid_rst_count",     64'(a.count),     64'd0);
        chk("mid_rst_out_valid", 64'(a.out_valid), 64'd0);
        chk("mid_rst_in_ready",  64'(a.in_ready),  64'd1);
        chk("mid_rst_L",         64'(a.L_out),     64'd0);
        chk("mid_rst_R",         64'(a.R_out),     64'd0);
        a.in_valid  = 1'b1;
        a.in_swap   = 1'b1;
        a.in_data   = 64'h7777_0000_0000_8888;
        a.out_ready = 1'b1;
        expect_entry(32'h00008888, 32'h77770000);
        cyc();
        a.in_valid = 1'b0;
        a.in_swap  = 1'b0;
        chk("post_rst_latency", 64'(a.out_valid), 64'd1);
        cyc();
        chk("post_rst_count", 64'(a.count), 64'd0);

        // Narrow instance: BLOCK_W=8, DEPTH=2
        b.in_valid = 1'b1;
        b.in_data  = 8'hA5;
        b.in_swap  = 1'b0;
        cyc();
        chk("w8_L",     64'(b.L_out), 64'hA);
        chk("w8_R",     64'(b.R_out), 64'h5);
        chk("w8_count", 64'(b.count), 64'd1);
        b.in_swap   = 1'b1;
        b.out_ready = 1'b1;
        cyc();
        b.in_valid = 1'b0;
        chk("w8_swap_L",     64'(b.L_out), 64'h5);
        chk("w8_swap_R",     64'(b.R_out), 64'hA);
        chk("w8_swap_count", 64'(b.count), 64'd1);
        cyc();
        chk("w8_empty_count", 64'(b.count),     64'd0);
        chk("w8_empty_valid", 64'(b.out_valid), 64'd0);

        cyc();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/block_split_fifo.md
BLOCK_SPLIT_FIFO -- requirements
Module: block_split_fifo

Interface
REQ-001 Parameter BLOCK_W, default 64: input block width; SHALL be even and at least 2; half width is H = BLOCK_W/2.
REQ-002 Parameter DEPTH, default 4: buffer entries; SHALL be a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_data, input, BLOCK_W bits: block to split.
REQ-006 Port in_swap, input, 1 bit: per-block swap mode, qualified by in_valid.
REQ-007 Port in_valid, input, 1 bit: producer asserts when in_data and in_swap are valid.
REQ-008 Port in_ready, output, 1 bit: block can accept a transfer.
REQ-009 Port L_out, output, H bits: left half of the head entry.
REQ-010 Port R_out, output, H bits: right half of the head entry.
REQ-011 Port out_valid, output, 1 bit: head entry present on L_out and R_out.
REQ-012 Port out_ready, input, 1 bit: consumer accepts the head entry.
REQ-013 Port count, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-014 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-015 A pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-016 On push with in_swap=0, the stored entry SHALL be L = in_data[BLOCK_W-1:H] and R = in_data[H-1:0].
REQ-017 On push with in_swap=1, the stored entry SHALL be L = in_data[H-1:0] and R = in_data[BLOCK_W-1:H] (final-round swap).
REQ-018 Split and swap SHALL be applied at write time; stored halves are never altered afterwards.
REQ-019 in_ready SHALL equal (count != DEPTH) and depend only on registered state; there is no combinational path from out_ready to in_ready.
REQ-020 out_valid SHALL equal (count != 0), driven from registered state.
REQ-021 L_out and R_out SHALL show the oldest unpopped entry.
  - Order is strict FIFO.
  - Values hold stable while out_valid=1 and out_ready=0.
REQ-022 Latency: a block pushed into an empty buffer SHALL appear with out_valid=1 on the cycle after the push edge; there is no same-cycle bypass.
REQ-023 Write and read pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-024 Count update per edge:
  - push only: +1
  - pop only: -1
  - both push and pop: unchanged, both pointers advance
  - neither: unchanged
REQ-025 Full (count=DEPTH): in_ready=0, so no push occurs even if out_ready=1 on the same cycle; in_ready returns to 1 on the cycle after a pop.
REQ-026 Empty (count=0): out_valid=0 and no pop occurs regardless of out_ready; L_out and R_out are don't-care but SHALL NOT be X after reset.
REQ-027 in_data and in_swap SHALL be ignored while in_valid=0 or in_ready=0.
REQ-028 Overflow and underflow SHALL be impossible by construction; count SHALL never exceed DEPTH or drop below 0.

Reset
REQ-029 While rst=1 at a rising edge, pointers and count SHALL go to 0, giving out_valid=0, in_ready=1 and L_out=R_out=0 on the following cycle.
REQ-030 rst SHALL take priority over a simultaneous push or pop.
  - All buffered entries are discarded.
  - An in-flight in_valid block is not captured.
REQ-031 Storage contents need not be cleared; only the visible outputs are forced to 0 while empty after reset.

Verification
REQ-032 Basic split, BLOCK_W=64, DEPTH=4: push 0x0123456789ABCDEF with swap=0 and out_ready=1 -> next cycle out_valid=1, L_out=0x01234567, R_out=0x89ABCDEF, then empty.
REQ-033 Swap: push 0x0123456789ABCDEF with swap=1 -> L_out=0x89ABCDEF, R_out=0x01234567.
REQ-034 Fill and backpressure: out_ready=0, push 5 blocks 0x1..0x5 -> in_ready=0 after the 4th push, count=4, 5th not accepted; then out_ready=1 pops 0x1 through 0x4 in order (R_out=1,2,3,4).
REQ-035 Simultaneous push/pop at count=2 with pointers wrapped past DEPTH-1 -> count stays 2 and output order is preserved across the wrap.
REQ-036 Reset mid-operation: count=3, assert rst with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, L_out=R_out=0; the next push appears with 1-cycle latency.
REQ-037 Width check, BLOCK_W=8, DEPTH=2: push 0xA5 with swap=0 -> L_out=0xA, R_out=0x5; with swap=1 -> L_out=0x5, R_out=0xA.
